multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the datapath, successor to the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives per-cycle datapath enables and ALU operation. Waits on a memory ready handshake with a bounded timeout. Adds the load, store and jump handling the single-cycle decoder lacks. Sits between the instruction register / memory interface and the datapath muxes, register file and PC.

---
 rtl/cu_pkg.sv | 58 +++++
 rtl/multicycle_control_unit_if.sv | 40 ++++
 rtl/cu_opcode_decoder.sv | 37 +++
 rtl/multicycle_control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its opcode decoder.
// The optional retired-instruction counter is enabled by defining CU_PERF_CNT_EN.
package cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
  } cu_state_e;

  // Opcode class one-hot bit positions; illegal is the top bit.
  localparam int CLS_NOP     = 0;
  localparam int CLS_ALU     = 1;
  localparam int CLS_BRANCH  = 2;
  localparam int CLS_LOAD    = 3;
  localparam int CLS_STORE   = 4;
  localparam int CLS_JUMP    = 5;
  localparam int CLS_ILLEGAL = 6;
  localparam int CLS_NUM     = 7;

  typedef logic [CLS_NUM-1:0] cls_onehot_t;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b001100;
  localparam logic [5:0] OP_STORE = 6'b001101;
  localparam logic [5:0] OP_JUMP  = 6'b001110;

  localparam int N_ALU_OPS = 4;
  localparam logic [N_ALU_OPS-1:0][5:0] ALU_OPS = {6'b001010, 6'b000100, 6'b000111, 6'b000001};

  localparam int N_BR_OPS = 3;
  localparam logic [N_BR_OPS-1:0][5:0] BR_OPS = {6'b001001, 6'b000110, 6'b000011};

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [5:0] ALU_ADD_DEF = 6'b000001;

  // States that stall on the memory ready handshake.
  function automatic logic is_wait_state(input cu_state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle: IR opcode, flags and handshake in,
// per-cycle datapath enables and ALU operation out.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_source;
  logic [ALUOP_W-1:0]  alu_op;
  logic                illegal_op;
  logic                bus_error;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal_op, bus_error
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal_op, bus_error
  );
endinterface

// File: rtl/cu_opcode_decoder.sv
// Combinational opcode -> class one-hot; shared with the single-cycle decode path.
module cu_opcode_decoder
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output cls_onehot_t         op_class
);

  logic [N_ALU_OPS-1:0] alu_hit;
  logic [N_BR_OPS-1:0]  br_hit;
  logic [CLS_NUM-2:0]   known;

  genvar gi;
  generate
    for (gi = 0; gi < N_ALU_OPS; gi++) begin : g_alu
      assign alu_hit[gi] = (opcode == OPCODE_W'(ALU_OPS[gi]));
    end
    for (gi = 0; gi < N_BR_OPS; gi++) begin : g_br
      assign br_hit[gi] = (opcode == OPCODE_W'(BR_OPS[gi]));
    end
  endgenerate

  always_comb begin
    known             = '0;
    known[CLS_NOP]    = (opcode == OPCODE_W'(OP_NOP));
    known[CLS_ALU]    = |alu_hit;
    known[CLS_BRANCH] = |br_hit;
    known[CLS_LOAD]   = (opcode == OPCODE_W'(OP_LOAD));
    known[CLS_STORE]  = (opcode == OPCODE_W'(OP_STORE));
    known[CLS_JUMP]   = (opcode == OPCODE_W'(OP_JUMP));
  end

  assign op_class = {~|known, known};

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing with a
// bounded mem_ready wait. Define CU_PERF_CNT_EN to add the instr_retired counter.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int                  OPCODE_W    = 6,
  parameter int                  ALUOP_W     = 6,
  parameter logic [ALUOP_W-1:0]  ALU_ADD     = ALUOP_W'(ALU_ADD_DEF),
  parameter int                  MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]               instr_retired
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MEM_TIMEOUT);

  cu_state_e           state_reg, state_next;
  logic [OPCODE_W-1:0] opcode_reg;
  logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
  cls_onehot_t         op_class;
  logic                timeout;

  cu_opcode_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode   (bus.opcode),
    .op_class (op_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      opcode_reg   <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_DECODE) begin
        opcode_reg <= bus.opcode;
      end
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      assign timeout = is_wait_state(state_reg) && !bus.mem_ready && (wait_cnt_reg == TO_VAL);
    end
  endgenerate

  // Any state change (or a timed-out FETCH re-entering itself) starts a fresh wait count.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if ((state_next != state_reg) || timeout) begin
      wait_cnt_next = '0;
    end else if (is_wait_state(state_reg) && (wait_cnt_reg != TO_VAL)) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next        = state_reg;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_RT;
    bus.pc_source     = PCSRC_ALU;
    bus.alu_op        = '0;
    bus.illegal_op    = 1'b0;
    bus.bus_error     = 1'b0;

    case (state_reg)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALU_ADD;
        if (bus.mem_ready) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.pc_source = PCSRC_ALU;
          state_next    = S_DECODE;
        end else if (timeout) begin
          bus.bus_error = 1'b1;
          state_next    = S_FETCH;
        end
      end

      S_DECODE: begin
        // Branch target precompute: PC + (imm << 2).
        bus.alu_src_b = SRCB_IMM_SH2;
        bus.alu_op    = ALU_ADD;
        if (op_class[CLS_ALU]) begin
          state_next = S_EXEC;
        end else if (op_class[CLS_BRANCH]) begin
          state_next = S_BRANCH;
        end else if (op_class[CLS_LOAD] || op_class[CLS_STORE]) begin
          state_next = S_MEM_ADDR;
        end else if (op_class[CLS_JUMP]) begin
          state_next = S_JUMP;
        end else if (op_class[CLS_NOP]) begin
          state_next = S_FETCH;
        end else begin
          bus.illegal_op = op_class[CLS_ILLEGAL];
          state_next     = S_FETCH;
        end
      end

      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_W'(opcode_reg);
        state_next    = S_ALU_WB;
      end

      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_next    = S_FETCH;
      end

      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALU_ADD;
        state_next    = (opcode_reg == OPCODE_W'(OP_LOAD)) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_MEM_WB;
        end else if (timeout) begin
          bus.bus_error = 1'b1;
          state_next    = S_FETCH;
        end
      end

      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_dst    = 1'b1;
        state_next     = S_FETCH;
      end

      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout) begin
          bus.bus_error = 1'b1;
          state_next    = S_FETCH;
        end
      end

      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALUOP_W'(opcode_reg);
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        state_next        = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
        state_next    = S_FETCH;
      end

      default: state_next = S_IDLE;
    endcase
  end

`ifdef CU_PERF_CNT_EN
  logic retire;

  // Only completed instructions count: aborted accesses and illegal opcodes do not.
  always_comb begin
    retire = 1'b0;
    if (state_next == S_FETCH) begin
      case (state_reg)
        S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
        S_MEM_WR: retire = bus.mem_ready;
        S_DECODE: retire = op_class[CLS_NOP];
        default:  retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
    end else if (retire) begin
      instr_retired <= instr_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=4); checks every control output each cycle.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  int         total = 0;
  int         bad = 0;
  logic [21:0] ctl;
`ifdef CU_PERF_CNT_EN
  logic [31:0] instr_retired;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(6)) bus ();

  assign bus.opcode    = opcode;
  assign bus.zero      = zero;
  assign bus.mem_ready = mem_ready;

  multicycle_control_unit #(
    .OPCODE_W    (6),
    .ALUOP_W     (6),
    .ALU_ADD     (6'b000001),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.master)
`ifdef CU_PERF_CNT_EN
    ,
    .instr_retired (instr_retired)
`endif
  );

  assign ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.pc_source, bus.alu_op, bus.illegal_op, bus.bus_error};

  function automatic logic [21:0] v(input logic pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa,
                                    input logic [1:0] asb, pcs, input logic [5:0] aop,
                                    input logic ill, be);
    return {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ill, be};
  endfunction

  function automatic logic [21:0] f_fetch(input logic rdy, be);
    return v(rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'd1, 2'd0, 6'b000001, 0, be);
  endfunction
  function automatic logic [21:0] f_dec(input logic ill);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 6'b000001, ill, 0);
  endfunction
  function automatic logic [21:0] f_exec(input logic [5:0] op);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, op, 0, 0);
  endfunction
  function automatic logic [21:0] f_alu_wb();
    return v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 6'd0, 0, 0);
  endfunction
  function automatic logic [21:0] f_maddr();
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 6'b000001, 0, 0);
  endfunction
  function automatic logic [21:0] f_mrd();
    return v(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 6'd0, 0, 0);
  endfunction
  function automatic logic [21:0] f_mwb();
    return v(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 2'd0, 6'd0, 0, 0);
  endfunction
  function automatic logic [21:0] f_mwr(input logic be);
    return v(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 6'd0, 0, be);
  endfunction
  function automatic logic [21:0] f_br(input logic [5:0] op);
    return v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, op, 0, 0);
  endfunction
  function automatic logic [21:0] f_jmp();
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 6'd0, 0, 0);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
    $display("check %s: got %h want %h", tag, obs, exp);
  endtask

  // Sample at the falling edge, then return just after the next rising edge.
  task automatic chk(input string tag, input logic [21:0] exp);
    @(negedge clk);
    cmp(tag, {10'd0, ctl}, {10'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 22'd0);
    rst_n = 1'b1;
    chk("idle", 22'd0);

    // ALU-imm 000001; opcode changes after DECODE must be ignored
    opcode = 6'b000001;
    chk("alu1_fetch", f_fetch(1, 0));
    chk("alu1_decode", f_dec(0));
    opcode = 6'b111111;
    chk("alu1_exec", f_exec(6'b000001));
    chk("alu1_wb", f_alu_wb());

    // ALU-imm 001010
    opcode = 6'b001010;
    chk("alu2_fetch", f_fetch(1, 0));
    chk("alu2_decode", f_dec(0));
    chk("alu2_exec", f_exec(6'b001010));
    chk("alu2_wb", f_alu_wb());

    // Load with 3 wait cycles in MEM_RD: 8 cycles total
    opcode = 6'b001100;
    chk("ld_fetch", f_fetch(1, 0));
    chk("ld_decode", f_dec(0));
    chk("ld_addr", f_maddr());
    mem_ready = 1'b0;
    chk("ld_rd_w0", f_mrd());
    chk("ld_rd_w1", f_mrd());
    chk("ld_rd_w2", f_mrd());
    mem_ready = 1'b1;
    chk("ld_rd_done", f_mrd());
    chk("ld_wb", f_mwb());

    // Branch 000011 with zero=1
    opcode = 6'b000011; zero = 1'b1;
    chk("br_fetch", f_fetch(1, 0));
    chk("br_decode", f_dec(0));
    chk("br_branch", f_br(6'b000011));
    zero = 1'b0;

    // Jump
    opcode = 6'b001110;
    chk("jmp_fetch", f_fetch(1, 0));
    chk("jmp_decode", f_dec(0));
    chk("jmp_jump", f_jmp());

    // NOP: two cycles
    opcode = 6'b000000;
    chk("nop_fetch", f_fetch(1, 0));
    chk("nop_decode", f_dec(0));

    // Illegal opcode
    opcode = 6'b111111;
    chk("ill_fetch", f_fetch(1, 0));
    chk("ill_decode", f_dec(1));
`ifdef CU_PERF_CNT_EN
    cmp("retired_after_illegal", instr_retired, 32'd6);
`endif

    // Store with two fetch wait cycles
    opcode = 6'b001101; mem_ready = 1'b0;
    chk("st_fetch_w0", f_fetch(0, 0));
    chk("st_fetch_w1", f_fetch(0, 0));
    mem_ready = 1'b1;
    chk("st_fetch", f_fetch(1, 0));
    chk("st_decode", f_dec(0));
    chk("st_addr", f_maddr());
    chk("st_wr", f_mwr(0));

    // Store timeout: 4 wait cycles, then bus_error and back to FETCH
    chk("sto_fetch", f_fetch(1, 0));
    chk("sto_decode", f_dec(0));
    chk("sto_addr", f_maddr());
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("sto_wr_w%0d", i), f_mwr(0));
    chk("sto_bus_error", f_mwr(1));
    chk("sto_back_fetch", f_fetch(0, 0));
    mem_ready = 1'b1;
    chk("sto_refetch", f_fetch(1, 0));

    // Store with mem_ready arriving exactly in the timeout cycle
    chk("stb_decode", f_dec(0));
    chk("stb_addr", f_maddr());
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("stb_wr_w%0d", i), f_mwr(0));
    mem_ready = 1'b1;
    chk("stb_wr_late_ready", f_mwr(0));

    // Fetch timeout, then counter restarts on re-entry
    mem_ready = 1'b0; opcode = 6'b001100;
    for (int i = 0; i < 4; i++) chk($sformatf("fto_w%0d", i), f_fetch(0, 0));
    chk("fto_bus_error", f_fetch(0, 1));
    for (int i = 0; i < 4; i++) chk($sformatf("fto_rewait%0d", i), f_fetch(0, 0));
`ifdef CU_PERF_CNT_EN
    cmp("retired_before_reset", instr_retired, 32'd8);
`endif

    // Load aborted by reset in MEM_WB
    mem_ready = 1'b1;
    chk("rl_fetch", f_fetch(1, 0));
    chk("rl_decode", f_dec(0));
    chk("rl_addr", f_maddr());
    chk("rl_rd", f_mrd());
    @(negedge clk);
    cmp("rl_wb", {10'd0, ctl}, {10'd0, f_mwb()});
    rst_n = 1'b0;
    #1;
    cmp("rl_async_reset", {10'd0, ctl}, 32'd0);
    @(posedge clk);
    #1;
    chk("rl_reset_hold", 22'd0);
    rst_n = 1'b1;
    chk("rl_idle", 22'd0);
`ifdef CU_PERF_CNT_EN
    cmp("retired_after_reset", instr_retired, 32'd0);
`endif
    chk("rl_post_fetch", f_fetch(1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
